// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA burst sequencer.
package dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CALC,
        ST_CMD,
        ST_WAIT,
        ST_DONE
    } dma_state_t;

    localparam int unsigned BEAT_BYTES     = 4;
    localparam int unsigned BOUNDARY_BYTES = 4096;
    localparam int unsigned AXI_LEN_W      = 8;

endpackage

// File: rtl/dma_burst_len_calc.sv
// Burst sizing: min of remaining beats, MAX_BURST_BEATS and the beats left
// before the next 4 KB boundary on both source and destination.
module dma_burst_len_calc
    import dma_pkg::*;
#(
    parameter int unsigned MAX_BURST_BEATS = 16
) (
    input  logic [29:0]          beats,
    input  logic [11:0]          src_off,
    input  logic [11:0]          dst_off,
    output logic [12:0]          burst_beats,
    output logic [AXI_LEN_W-1:0] axi_len
);

    localparam logic [12:0] BOUND_B = 13'(BOUNDARY_BYTES);
    localparam logic [12:0] MAX_B   = 13'(MAX_BURST_BEATS);

    logic [12:0] src_room;
    logic [12:0] dst_room;

    always_comb begin
        // Room is 1..1024 beats; offsets are word aligned so the shift is exact.
        src_room = (BOUND_B - {1'b0, src_off}) >> 2;
        dst_room = (BOUND_B - {1'b0, dst_off}) >> 2;

        burst_beats = (beats > 30'(MAX_BURST_BEATS)) ? MAX_B : beats[12:0];
        if (src_room < burst_beats) burst_beats = src_room;
        if (dst_room < burst_beats) burst_beats = dst_room;

        axi_len = AXI_LEN_W'(burst_beats - 13'd1);
    end

endmodule

// File: rtl/dma_burst_ctrl.sv
// DMA transfer sequencer: splits a programmed copy into 4 KB-safe AXI bursts
// and issues paired read/write burst commands, pulsing done at the end.
module dma_burst_ctrl
    import dma_pkg::*;
#(
    parameter int unsigned MAX_BURST_BEATS = 16,
    parameter int unsigned ADDR_WIDTH      = 32
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  i_dma_start,
    input  logic [ADDR_WIDTH-1:0] i_src_addr,
    input  logic [ADDR_WIDTH-1:0] i_dst_addr,
    input  logic [31:0]           i_trf_len,
    output logic                  o_dma_done,
    output logic                  o_busy,
    output logic                  o_rd_cmd_valid,
    input  logic                  i_rd_cmd_ready,
    output logic [ADDR_WIDTH-1:0] o_rd_cmd_addr,
    output logic [AXI_LEN_W-1:0]  o_rd_cmd_len,
    input  logic                  i_rd_done,
    output logic                  o_wr_cmd_valid,
    input  logic                  i_wr_cmd_ready,
    output logic [ADDR_WIDTH-1:0] o_wr_cmd_addr,
    output logic [AXI_LEN_W-1:0]  o_wr_cmd_len,
    input  logic                  i_wr_done
);

    dma_state_t state_q, state_d;

    logic                  start_q;
    logic [ADDR_WIDTH-1:0] src_q, dst_q;
    logic [29:0]           beats_q;
    logic [12:0]           burst_q;
    logic [AXI_LEN_W-1:0]  len_q;
    logic                  rd_acc, wr_acc, rd_dn, wr_dn;

    logic                  start_rise;
    logic                  rd_acc_n, wr_acc_n, rd_dn_n, wr_dn_n;
    logic [29:0]           beats_rem;
    logic [ADDR_WIDTH-1:0] step;
    logic [12:0]           calc_beats;
    logic [AXI_LEN_W-1:0]  calc_len;
    logic                  unused_low_bits;

    dma_burst_len_calc #(
        .MAX_BURST_BEATS(MAX_BURST_BEATS)
    ) u_len_calc (
        .beats      (beats_q),
        .src_off    (src_q[11:0]),
        .dst_off    (dst_q[11:0]),
        .burst_beats(calc_beats),
        .axi_len    (calc_len)
    );

    always_comb begin
        start_rise      = i_dma_start & ~start_q;
        rd_acc_n        = rd_acc | (o_rd_cmd_valid & i_rd_cmd_ready);
        wr_acc_n        = wr_acc | (o_wr_cmd_valid & i_wr_cmd_ready);
        rd_dn_n         = rd_dn | i_rd_done;
        wr_dn_n         = wr_dn | i_wr_done;
        beats_rem       = beats_q - 30'(burst_q);
        step            = ADDR_WIDTH'({burst_q, 2'b00});
        unused_low_bits = ^{i_trf_len[1:0], i_src_addr[1:0], i_dst_addr[1:0]};
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_rise) state_d = ST_CALC;
            ST_CALC: state_d = (beats_q == '0) ? ST_DONE : ST_CMD;
            ST_CMD:  if (rd_acc_n && wr_acc_n) state_d = ST_WAIT;
            ST_WAIT: if (rd_dn_n && wr_dn_n)
                         state_d = (beats_rem == '0) ? ST_DONE : ST_CALC;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_dma_done     = (state_q == ST_DONE);
        o_busy         = (state_q != ST_IDLE);
        o_rd_cmd_valid = (state_q == ST_CMD) && !rd_acc;
        o_wr_cmd_valid = (state_q == ST_CMD) && !wr_acc;
        o_rd_cmd_addr  = src_q;
        o_wr_cmd_addr  = dst_q;
        o_rd_cmd_len   = len_q;
        o_wr_cmd_len   = len_q;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            start_q <= 1'b0;
            src_q   <= '0;
            dst_q   <= '0;
            beats_q <= '0;
            burst_q <= '0;
            len_q   <= '0;
            rd_acc  <= 1'b0;
            wr_acc  <= 1'b0;
            rd_dn   <= 1'b0;
            wr_dn   <= 1'b0;
        end else begin
            start_q <= i_dma_start;
            case (state_q)
                ST_IDLE: if (start_rise) begin
                    src_q   <= {i_src_addr[ADDR_WIDTH-1:2], 2'b00};
                    dst_q   <= {i_dst_addr[ADDR_WIDTH-1:2], 2'b00};
                    beats_q <= i_trf_len[31:2];
                end
                ST_CALC: begin
                    burst_q <= calc_beats;
                    len_q   <= calc_len;
                    rd_acc  <= 1'b0;
                    wr_acc  <= 1'b0;
                    rd_dn   <= 1'b0;
                    wr_dn   <= 1'b0;
                end
                ST_CMD: begin
                    rd_acc <= rd_acc_n;
                    wr_acc <= wr_acc_n;
                    rd_dn  <= rd_dn_n;
                    wr_dn  <= wr_dn_n;
                end
                ST_WAIT: begin
                    rd_dn <= rd_dn_n;
                    wr_dn <= wr_dn_n;
                    if (rd_dn_n && wr_dn_n) begin
                        src_q   <= src_q + step;
                        dst_q   <= dst_q + step;
                        beats_q <= beats_rem;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_burst_ctrl.sv
// Directed bench for dma_burst_ctrl with a simple read/write master responder.
`timescale 1ns/1ps

`define CHK(tag, obs, exp) begin \
    tests++; \
    assert ((obs) === (exp)) else begin \
        fails++; \
        $error("FAIL %s observed=%0h expected=%0h", tag, (obs), (exp)); \
    end \
end

module tb_dma_burst_ctrl;

    logic        ACLK, ARESET;
    logic        i_dma_start;
    logic [31:0] i_src_addr, i_dst_addr, i_trf_len;
    logic        o_dma_done, o_busy;
    logic        o_rd_cmd_valid, i_rd_cmd_ready, i_rd_done;
    logic        o_wr_cmd_valid, i_wr_cmd_ready, i_wr_done;
    logic [31:0] o_rd_cmd_addr, o_wr_cmd_addr;
    logic [7:0]  o_rd_cmd_len, o_wr_cmd_len;

    int tests = 0;
    int fails = 0;

    int rd_delay = 0, wr_delay = 0;
    int rd_wait = 0, wr_wait = 0, rd_dcnt = 0, wr_dcnt = 0;
    int done_pulses = 0, rdlow_wrhigh = 0, stab_err = 0;
    logic        rd_pend = 1'b0, wr_pend = 1'b0;
    logic [31:0] prev_ra, prev_wa;
    logic [7:0]  prev_rl, prev_wl;
    logic [31:0] rd_addr_q[$], wr_addr_q[$];
    logic [7:0]  rd_len_q[$], wr_len_q[$];

    dma_burst_ctrl #(
        .MAX_BURST_BEATS(16),
        .ADDR_WIDTH     (32)
    ) dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .i_dma_start   (i_dma_start),
        .i_src_addr    (i_src_addr),
        .i_dst_addr    (i_dst_addr),
        .i_trf_len     (i_trf_len),
        .o_dma_done    (o_dma_done),
        .o_busy        (o_busy),
        .o_rd_cmd_valid(o_rd_cmd_valid),
        .i_rd_cmd_ready(i_rd_cmd_ready),
        .o_rd_cmd_addr (o_rd_cmd_addr),
        .o_rd_cmd_len  (o_rd_cmd_len),
        .i_rd_done     (i_rd_done),
        .o_wr_cmd_valid(o_wr_cmd_valid),
        .i_wr_cmd_ready(i_wr_cmd_ready),
        .o_wr_cmd_addr (o_wr_cmd_addr),
        .o_wr_cmd_len  (o_wr_cmd_len),
        .i_wr_done     (i_wr_done)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    // Master responder: ready after a configurable delay, done pulse 3 cycles after handshake.
    initial begin
        i_rd_cmd_ready = 1'b0;
        i_wr_cmd_ready = 1'b0;
        i_rd_done      = 1'b0;
        i_wr_done      = 1'b0;
        forever begin
            @(negedge ACLK);
            i_rd_done = 1'b0;
            i_wr_done = 1'b0;
            if (ARESET) begin
                rd_dcnt = 0; wr_dcnt = 0; rd_wait = 0; wr_wait = 0;
                rd_pend = 1'b0; wr_pend = 1'b0;
                i_rd_cmd_ready = 1'b0;
                i_wr_cmd_ready = 1'b0;
            end else begin
                if (rd_dcnt > 0) begin rd_dcnt--; if (rd_dcnt == 0) i_rd_done = 1'b1; end
                if (wr_dcnt > 0) begin wr_dcnt--; if (wr_dcnt == 0) i_wr_done = 1'b1; end
                if (o_dma_done) done_pulses++;
                if (!o_rd_cmd_valid && o_wr_cmd_valid) rdlow_wrhigh++;
                if (rd_pend && (o_rd_cmd_valid !== 1'b1 || o_rd_cmd_addr !== prev_ra ||
                                o_rd_cmd_len !== prev_rl)) stab_err++;
                if (wr_pend && (o_wr_cmd_valid !== 1'b1 || o_wr_cmd_addr !== prev_wa ||
                                o_wr_cmd_len !== prev_wl)) stab_err++;

                if (o_rd_cmd_valid) begin i_rd_cmd_ready = (rd_wait >= rd_delay); rd_wait++; end
                else begin rd_wait = 0; i_rd_cmd_ready = (rd_delay == 0); end
                if (o_wr_cmd_valid) begin i_wr_cmd_ready = (wr_wait >= wr_delay); wr_wait++; end
                else begin wr_wait = 0; i_wr_cmd_ready = (wr_delay == 0); end

                if (o_rd_cmd_valid && i_rd_cmd_ready) begin
                    rd_addr_q.push_back(o_rd_cmd_addr);
                    rd_len_q.push_back(o_rd_cmd_len);
                    rd_dcnt = 3;
                end
                if (o_wr_cmd_valid && i_wr_cmd_ready) begin
                    wr_addr_q.push_back(o_wr_cmd_addr);
                    wr_len_q.push_back(o_wr_cmd_len);
                    wr_dcnt = 3;
                end
                rd_pend = o_rd_cmd_valid && !i_rd_cmd_ready;
                wr_pend = o_wr_cmd_valid && !i_wr_cmd_ready;
                prev_ra = o_rd_cmd_addr; prev_rl = o_rd_cmd_len;
                prev_wa = o_wr_cmd_addr; prev_wl = o_wr_cmd_len;
            end
        end
    end

    task automatic tick();
        @(negedge ACLK);
        #1;
    endtask

    task automatic clear_logs();
        rd_addr_q.delete(); wr_addr_q.delete();
        rd_len_q.delete();  wr_len_q.delete();
        done_pulses = 0; rdlow_wrhigh = 0; stab_err = 0;
    endtask

    // Returns one tick after the sampling edge, i.e. with the DUT in CALC.
    task automatic start_xfer(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l);
        i_src_addr  = s;
        i_dst_addr  = d;
        i_trf_len   = l;
        i_dma_start = 1'b1;
        tick();
        i_dma_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (o_dma_done === 1'b1) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    logic ok;
    int   addr_err;
    int   seen_before;

    initial begin
        ARESET = 1'b1;
        i_dma_start = 1'b0;
        i_src_addr = '0; i_dst_addr = '0; i_trf_len = '0;
        tick(); tick();
        `CHK("rst_busy", o_busy, 1'b0)
        `CHK("rst_done", o_dma_done, 1'b0)
        `CHK("rst_rdv", o_rd_cmd_valid, 1'b0)
        `CHK("rst_wrv", o_wr_cmd_valid, 1'b0)
        `CHK("rst_rdaddr", o_rd_cmd_addr, 32'h0)
        ARESET = 1'b0;
        tick();

        // Single aligned burst
        clear_logs();
        start_xfer(32'h1000, 32'h2000, 32'd64);
        `CHK("t1_calc_busy", o_busy, 1'b1)
        `CHK("t1_calc_rdv", o_rd_cmd_valid, 1'b0)
        tick();
        `CHK("t1_cmd_rdv", o_rd_cmd_valid, 1'b1)
        `CHK("t1_cmd_wrv", o_wr_cmd_valid, 1'b1)
        `CHK("t1_rd_addr", o_rd_cmd_addr, 32'h1000)
        `CHK("t1_wr_addr", o_wr_cmd_addr, 32'h2000)
        `CHK("t1_rd_len", o_rd_cmd_len, 8'd15)
        `CHK("t1_wr_len", o_wr_cmd_len, 8'd15)
        wait_done(200, ok);
        `CHK("t1_done_seen", ok, 1'b1)
        `CHK("t1_busy_at_done", o_busy, 1'b1)
        tick();
        `CHK("t1_busy_after", o_busy, 1'b0)
        `CHK("t1_nrd", rd_addr_q.size(), 1)
        `CHK("t1_nwr", wr_addr_q.size(), 1)
        `CHK("t1_ndone", done_pulses, 1)

        // Source crosses a 4 KB boundary after 4 beats
        clear_logs();
        start_xfer(32'h0FF0, 32'h3000, 32'd64);
        wait_done(300, ok);
        `CHK("t2_done_seen", ok, 1'b1)
        tick();
        `CHK("t2_nrd", rd_addr_q.size(), 2)
        `CHK("t2_nwr", wr_addr_q.size(), 2)
        `CHK("t2_rd0_addr", rd_addr_q[0], 32'h0FF0)
        `CHK("t2_rd0_len", rd_len_q[0], 8'd3)
        `CHK("t2_wr0_addr", wr_addr_q[0], 32'h3000)
        `CHK("t2_wr0_len", wr_len_q[0], 8'd3)
        `CHK("t2_rd1_addr", rd_addr_q[1], 32'h1000)
        `CHK("t2_rd1_len", rd_len_q[1], 8'd11)
        `CHK("t2_wr1_addr", wr_addr_q[1], 32'h3010)
        `CHK("t2_wr1_len", wr_len_q[1], 8'd11)
        `CHK("t2_ndone", done_pulses, 1)

        // Zero-beat transfers: len 0 and len 3
        clear_logs();
        start_xfer(32'h1000, 32'h2000, 32'd0);
        `CHK("t3a_calc_done", o_dma_done, 1'b0)
        `CHK("t3a_calc_busy", o_busy, 1'b1)
        tick();
        `CHK("t3a_done", o_dma_done, 1'b1)
        `CHK("t3a_rdv", o_rd_cmd_valid, 1'b0)
        tick();
        `CHK("t3a_busy_after", o_busy, 1'b0)
        start_xfer(32'h1000, 32'h2000, 32'd3);
        `CHK("t3b_calc_done", o_dma_done, 1'b0)
        tick();
        `CHK("t3b_done", o_dma_done, 1'b1)
        `CHK("t3b_wrv", o_wr_cmd_valid, 1'b0)
        tick();
        `CHK("t3_ncmd", rd_addr_q.size() + wr_addr_q.size(), 0)
        `CHK("t3_ndone", done_pulses, 2)

        // 256 beats in 16-beat bursts, write ready lags 5 cycles
        clear_logs();
        wr_delay = 5;
        start_xfer(32'h4000, 32'h8000, 32'd1024);
        wait_done(2000, ok);
        `CHK("t4_done_seen", ok, 1'b1)
        tick();
        wr_delay = 0;
        `CHK("t4_nrd", rd_addr_q.size(), 16)
        `CHK("t4_nwr", wr_addr_q.size(), 16)
        addr_err = 0;
        for (int i = 0; i < 16; i++) begin
            if (rd_addr_q[i] !== 32'h4000 + 32'(i * 64) || rd_len_q[i] !== 8'd15) addr_err++;
            if (wr_addr_q[i] !== 32'h8000 + 32'(i * 64) || wr_len_q[i] !== 8'd15) addr_err++;
        end
        `CHK("t4_addr_step", addr_err, 0)
        `CHK("t4_rdlow_wrhigh", rdlow_wrhigh, 80)
        `CHK("t4_stable", stab_err, 0)
        `CHK("t4_ndone", done_pulses, 1)

        // Start held high for 1000 cycles runs exactly one transfer
        clear_logs();
        i_src_addr = 32'h1000; i_dst_addr = 32'h2000; i_trf_len = 32'd64;
        i_dma_start = 1'b1;
        for (int i = 0; i < 1000; i++) tick();
        i_dma_start = 1'b0;
        tick();
        `CHK("t5a_ndone", done_pulses, 1)
        `CHK("t5a_nrd", rd_addr_q.size(), 1)

        // Start pulse during WAIT is ignored
        clear_logs();
        start_xfer(32'h1000, 32'h2000, 32'd64);
        tick(); tick();
        `CHK("t5b_wait_busy", o_busy, 1'b1)
        `CHK("t5b_wait_rdv", o_rd_cmd_valid, 1'b0)
        i_dma_start = 1'b1;
        tick();
        i_dma_start = 1'b0;
        wait_done(200, ok);
        `CHK("t5b_done_seen", ok, 1'b1)
        for (int i = 0; i < 10; i++) tick();
        `CHK("t5b_ndone", done_pulses, 1)
        `CHK("t5b_nrd", rd_addr_q.size(), 1)
        `CHK("t5b_busy", o_busy, 1'b0)

        // Reset during WAIT of burst 2 aborts without a done pulse
        clear_logs();
        start_xfer(32'h4000, 32'h8000, 32'd1024);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (rd_addr_q.size() == 2) begin ok = 1'b1; break; end
            tick();
        end
        `CHK("t6_burst2_seen", ok, 1'b1)
        tick();
        `CHK("t6_in_wait", o_busy & ~o_rd_cmd_valid & ~o_wr_cmd_valid, 1'b1)
        seen_before = done_pulses;
        ARESET = 1'b1;
        #1;
        `CHK("t6_rst_busy", o_busy, 1'b0)
        `CHK("t6_rst_rdv", o_rd_cmd_valid, 1'b0)
        `CHK("t6_rst_wrv", o_wr_cmd_valid, 1'b0)
        `CHK("t6_rst_rdaddr", o_rd_cmd_addr, 32'h0)
        `CHK("t6_rst_wraddr", o_wr_cmd_addr, 32'h0)
        `CHK("t6_rst_len", {o_rd_cmd_len, o_wr_cmd_len}, 16'h0)
        tick(); tick();
        `CHK("t6_rst_nodone", done_pulses, seen_before)
        `CHK("t6_rst_done_lo", o_dma_done, 1'b0)
        ARESET = 1'b0;
        tick();
        clear_logs();
        start_xfer(32'h2FF8, 32'h5002, 32'd16);
        wait_done(300, ok);
        `CHK("t6_done_seen", ok, 1'b1)
        tick();
        `CHK("t6_nrd", rd_addr_q.size(), 2)
        `CHK("t6_rd0_addr", rd_addr_q[0], 32'h2FF8)
        `CHK("t6_rd0_len", rd_len_q[0], 8'd1)
        `CHK("t6_wr0_addr", wr_addr_q[0], 32'h5000)
        `CHK("t6_rd1_addr", rd_addr_q[1], 32'h3000)
        `CHK("t6_wr1_addr", wr_addr_q[1], 32'h5008)
        `CHK("t6_wr1_len", wr_len_q[1], 8'd1)
        `CHK("t6_ndone", done_pulses, 1)

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
